// File: rtl/run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl_pkg
// Description : Shared types and constants for the run controller: the
//               controller state encoding, data-memory address/data widths
//               and the default operand/result base addresses.
// Revision    : 1.0  initial release
// ============================================================================
package run_ctrl_pkg;

    localparam int DM_AW = 8;   // data-memory address width
    localparam int DW    = 8;   // data-memory word width

    localparam logic [DM_AW-1:0] LD_BASE_DEF = 8'd1;
    localparam logic [DM_AW-1:0] RD_BASE_DEF = 8'd5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } run_state_t;

endpackage
`default_nettype wire

// File: rtl/run_ctrl_wdog.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl_wdog
// Description : Saturating CW-bit cycle counter with synchronous clear and
//               count enable, plus a terminal-count compare.
// Ports       : clk, rst_n      clock, asynchronous active-low reset
//               clr             zero the counter (wins over en)
//               en              count this cycle (holds at all-ones)
//               count           current count
//               at_limit        high when the next enabled count reaches LIMIT
// Revision    : 1.0  initial release
// ============================================================================
module run_ctrl_wdog
    import run_ctrl_pkg::*;
#(
    parameter int CW    = 16,
    parameter int LIMIT = 1024
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          at_limit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CW'(1);
        end
    end

    // Looks one count ahead so the owner can leave RUN on the very cycle the
    // count lands on LIMIT, giving exactly LIMIT cycles in RUN.
    assign at_limit = en && (count == CW'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : run_ctrl
// Description : Host-side run controller for the single-cycle core. Preloads
//               NUM_LD operand words into data memory, launches the core with
//               the Start/Ack handshake, then streams NUM_RD result words back.
// Ports       : Clk, Reset                     clock, async active-low reset
//               Go, Busy                        run request / activity flag
//               LdValid, LdData, LdReady        operand stream in
//               DmWrEn, DmAddr, DmWrData        data-memory write/address
//               DmRdData                        data-memory read data
//               CpuStart, CpuAck                core handshake
//               ResValid, ResData, ResReady     result stream out
//               Done, Error, CycleCount         run status
// Options     : RUN_CTRL_WATCHDOG_EN  enables the RUN timeout and ERR state;
//               without it RUN waits for CpuAck forever and Error is 0.
// Revision    : 1.0  initial release
// ============================================================================
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int               NUM_LD         = 4,
    parameter logic [DM_AW-1:0] LD_BASE        = LD_BASE_DEF,
    parameter int               NUM_RD         = 4,
    parameter logic [DM_AW-1:0] RD_BASE        = RD_BASE_DEF,
    parameter int               START_HOLD     = 2,
    parameter int               TIMEOUT_CYCLES = 1024,
    parameter int               CW             = 16
)(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Go,
    output logic             Busy,
    input  logic             LdValid,
    input  logic [DW-1:0]    LdData,
    output logic             LdReady,
    output logic             DmWrEn,
    output logic [DM_AW-1:0] DmAddr,
    output logic [DW-1:0]    DmWrData,
    input  logic [DW-1:0]    DmRdData,
    output logic             CpuStart,
    input  logic             CpuAck,
    output logic             ResValid,
    output logic [DW-1:0]    ResData,
    input  logic             ResReady,
    output logic             Done,
    output logic             Error,
    output logic [CW-1:0]    CycleCount
);

    localparam int         HW        = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
    localparam logic [7:0] LAST_LD   = 8'(NUM_LD - 1);
    localparam logic [7:0] LAST_RD   = 8'(NUM_RD - 1);
    localparam logic [HW-1:0] LAST_HOLD = HW'(START_HOLD - 1);

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif

    run_state_t    state, state_next;
    logic [7:0]    idx, idx_next;
    logic [HW-1:0] hold_cnt, hold_next;
    logic          cnt_clr, cnt_en;
    logic          at_limit;
    logic          timeout;

    run_ctrl_wdog #(
        .CW    (CW),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk      (Clk),
        .rst_n    (Reset),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .count    (CycleCount),
        .at_limit (at_limit)
    );

    // Constant-folds to 0 in the default build, leaving ERR unreachable.
    assign timeout = WDOG_EN && at_limit;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            hold_cnt <= hold_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        hold_next  = hold_cnt;
        Busy       = (state != S_IDLE);
        LdReady    = 1'b0;
        DmWrEn     = 1'b0;
        DmAddr     = '0;
        DmWrData   = '0;
        CpuStart   = 1'b1;   // core stays parked unless running or draining
        ResValid   = 1'b0;
        ResData    = '0;
        Done       = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        case (state)
            S_IDLE: begin
                if (Go) begin
                    cnt_clr    = 1'b1;
                    idx_next   = '0;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                LdReady = 1'b1;
                DmAddr  = LD_BASE + idx;
                if (LdValid) begin
                    DmWrEn   = 1'b1;
                    DmWrData = LdData;
                    if (idx == LAST_LD) begin
                        idx_next   = '0;
                        hold_next  = '0;
                        state_next = S_START;
                    end else begin
                        idx_next = idx + 8'd1;
                    end
                end
            end
            S_START: begin
                if (hold_cnt == LAST_HOLD) begin
                    state_next = S_RUN;
                end else begin
                    hold_next = hold_cnt + HW'(1);
                end
            end
            S_RUN: begin
                CpuStart = 1'b0;
                if (CpuAck) begin
                    idx_next   = '0;
                    state_next = S_READ;
                end else begin
                    cnt_en = 1'b1;
                    if (timeout) begin
                        state_next = S_ERR;
                    end
                end
            end
            S_READ: begin
                // Keep Start low so the core does not restart and overwrite
                // the results being read.
                CpuStart = 1'b0;
                DmAddr   = RD_BASE + idx;
                ResValid = 1'b1;
                ResData  = DmRdData;
                if (ResReady) begin
                    if (idx == LAST_RD) begin
                        idx_next   = '0;
                        state_next = S_DONE;
                    end else begin
                        idx_next = idx + 8'd1;
                    end
                end
            end
            S_DONE: begin
                Done       = 1'b1;
                state_next = S_IDLE;
            end
            S_ERR: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

`ifdef RUN_CTRL_WATCHDOG_EN
    logic error_flag;

    // Sticky until the host accepts a new run.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            error_flag <= 1'b0;
        end else if ((state == S_IDLE) && Go) begin
            error_flag <= 1'b0;
        end else if (state_next == S_ERR) begin
            error_flag <= 1'b1;
        end
    end

    assign Error = error_flag;
`else
    assign Error = 1'b0;
`endif

endmodule
`default_nettype wire
